// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter for an out-of-order core. Each functional unit owns
// a one-entry holding buffer. Every cycle one occupied buffer is picked and its
// result is broadcast on the registered bus_* outputs at the next edge.
//
// Winner selection:
//   default              : round-robin starting at rr_ptr; rob_head is ignored.
//   CDB_AGE_PRIORITY_EN  : the oldest entry wins. Age is (rob_idx - rob_head)
//                          modulo 2^ROB_IDX_WIDTH, and ties go to the lowest
//                          unit index. rr_ptr is held at 0.
//
// Handshake (per unit i):
//   A transfer happens at a rising edge when req_valid[i] && req_ready[i].
//   req_ready[i] = !rst && !flush && (buffer empty || buffer granted this
//   cycle). A granted buffer can therefore take a new payload at the same
//   edge, so one result per cycle per unit is sustained. The unit may change
//   or drop its payload while req_ready is low.
//
// Ports:
//   clk, rst (sync, active-high), flush
//   rob_head                               ROB head, used only for age priority
//   req_valid / req_ready                  per-unit handshake
//   req_rob_idx / req_rd_addr / req_data   per-unit payload (packed arrays)
//   bus_valid, bus_src, bus_rob_idx,       registered broadcast; the payload
//   bus_rd_addr, bus_data                  fields hold when bus_valid is 0
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 32,
  parameter  int ROB_IDX_WIDTH  = 5,
  parameter  int REG_ADDR_WIDTH = 5,
  localparam int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic [ROB_IDX_WIDTH-1:0]                     rob_head,
  input  logic [NUM_REQ-1:0]                           req_valid,
  output logic [NUM_REQ-1:0]                           req_ready,
  input  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]        req_rob_idx,
  input  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0]       req_rd_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]           req_data,
  output logic                                         bus_valid,
  output logic [SRC_W-1:0]                             bus_src,
  output logic [ROB_IDX_WIDTH-1:0]                     bus_rob_idx,
  output logic [REG_ADDR_WIDTH-1:0]                    bus_rd_addr,
  output logic [DATA_WIDTH-1:0]                        bus_data
);

  // Holding buffers
  logic [NUM_REQ-1:0]                     r_occ;
  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]  r_rob_idx;
  logic [NUM_REQ-1:0][REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     r_data;

  // Round-robin pointer (held at 0 in age mode)
  logic [SRC_W-1:0]                       r_rr_ptr;

  // Broadcast registers
  logic                                   r_bus_valid;
  logic [SRC_W-1:0]                       r_bus_src;
  logic [ROB_IDX_WIDTH-1:0]               r_bus_rob_idx;
  logic [REG_ADDR_WIDTH-1:0]              r_bus_rd_addr;
  logic [DATA_WIDTH-1:0]                  r_bus_data;

  // Arbitration result
  logic                                   w_any;
  logic [SRC_W-1:0]                       w_win;
  logic [NUM_REQ-1:0]                     w_grant;

  // (base + k) mod NUM_REQ without a divider; k is always < NUM_REQ.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                input int                k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[SRC_W-1:0];
  endfunction

`ifdef CDB_AGE_PRIORITY_EN
  logic [ROB_IDX_WIDTH-1:0] w_best_age;
  logic                     w_unused_rr;

  // Modular subtraction gives the distance from the ROB head, so an entry
  // just behind the head after a wrap still counts as young.
  function automatic logic [ROB_IDX_WIDTH-1:0] age_of(
    input logic [ROB_IDX_WIDTH-1:0] idx,
    input logic [ROB_IDX_WIDTH-1:0] head);
    return idx - head;
  endfunction

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_best_age = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_occ[i] && (!w_any || (age_of(r_rob_idx[i], rob_head) < w_best_age))) begin
        w_any      = 1'b1;
        w_win      = SRC_W'(i);
        w_best_age = age_of(r_rob_idx[i], rob_head);
      end
    end
  end

  assign w_unused_rr = ^r_rr_ptr;
`else
  logic w_unused_head;

  // First occupied buffer in the order rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && r_occ[wrap_add(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_win = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_unused_head = ^rob_head;
`endif

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_grant
      assign w_grant[g]   = w_any && (w_win == SRC_W'(g));
      assign req_ready[g] = !rst && !flush && (!r_occ[g] || w_grant[g]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ         <= '0;
      r_rr_ptr      <= '0;
      r_bus_valid   <= 1'b0;
      r_bus_src     <= '0;
      r_bus_rob_idx <= '0;
      r_bus_rd_addr <= '0;
      r_bus_data    <= '0;
    end else if (flush) begin
      // Buffered results are dropped and nothing is broadcast; the bus
      // payload fields keep their last values like any idle cycle.
      r_occ       <= '0;
      r_rr_ptr    <= '0;
      r_bus_valid <= 1'b0;
    end else begin
      r_bus_valid <= w_any;
      if (w_any) begin
        r_bus_src     <= w_win;
        r_bus_rob_idx <= r_rob_idx[w_win];
        r_bus_rd_addr <= r_rd_addr[w_win];
        r_bus_data    <= r_data[w_win];
`ifndef CDB_AGE_PRIORITY_EN
        r_rr_ptr      <= wrap_add(w_win, 1);
`endif
      end
      // A new accept overrides the grant clear, which is what gives the
      // back-to-back, bubble-free path.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          r_occ[i]     <= 1'b1;
          r_rob_idx[i] <= req_rob_idx[i];
          r_rd_addr[i] <= req_rd_addr[i];
          r_data[i]    <= req_data[i];
        end else if (w_grant[i]) begin
          r_occ[i]     <= 1'b0;
        end
      end
    end
  end

  assign bus_valid   = r_bus_valid;
  assign bus_src     = r_bus_src;
  assign bus_rob_idx = r_bus_rob_idx;
  assign bus_rd_addr = r_bus_rd_addr;
  assign bus_data    = r_bus_data;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The parameters SHALL be:
  - NUM_REQ, default 4, number of functional-unit requesters (0=ALU, 1=MUL, 2=BR, 3=MEM).
  - DATA_WIDTH, default 32, result width.
  - ROB_IDX_WIDTH, default 5, ROB index width.
  - REG_ADDR_WIDTH, default 5, architectural rd width.
REQ-002 The ports SHALL be:
  - clk  in  1  clock.
  - rst  in  1  reset: synchronous, active-high.
  - flush  in  1  pipeline flush.
  - rob_head  in  ROB_IDX_WIDTH  current ROB head, used for age priority.
  - req_valid  in  NUM_REQ  per-unit result valid.
  - req_ready  out  NUM_REQ  per-unit holding buffer can accept.
  - req_rob_idx  in  NUM_REQ x ROB_IDX_WIDTH  per-unit ROB index.
  - req_rd_addr  in  NUM_REQ x REG_ADDR_WIDTH  per-unit destination register.
  - req_data  in  NUM_REQ x DATA_WIDTH  per-unit result.
  - bus_valid  out  1  broadcast valid.
  - bus_src  out  $clog2(NUM_REQ)  winning unit id.
  - bus_rob_idx  out  ROB_IDX_WIDTH  broadcast ROB index.
  - bus_rd_addr  out  REG_ADDR_WIDTH  broadcast rd.
  - bus_data  out  DATA_WIDTH  broadcast result.

Function
REQ-003 Each requester SHALL own one holding buffer (occupied flag plus rob_idx, rd_addr, data).
REQ-004 req_ready[i] SHALL be 1 when buffer i is empty or is granted in the current cycle; it SHALL be 0 while flush is high.
REQ-005 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1 at a rising edge; the payload is captured into buffer i.
REQ-006 Each cycle, arbitration SHALL be combinational over the occupied buffers, and exactly one winner SHALL be granted when any buffer is occupied.
REQ-007 The winner's payload and id SHALL be registered onto the bus_* outputs at the next edge, giving bus_valid=1 for exactly one cycle per grant.
REQ-008 The granted buffer SHALL be cleared at the same edge.
REQ-009 Latency SHALL be one cycle from request acceptance to bus_valid when uncontended.
REQ-010 If a requester's buffer is granted and a new request is accepted in the same cycle, the buffer SHALL hold the new payload with no bubble, sustaining one result per cycle per unit.
REQ-011 Round-robin mode SHALL use a pointer rr_ptr:
  - search order rr_ptr, rr_ptr+1, ... modulo NUM_REQ;
  - after a grant to i, rr_ptr = (i+1) mod NUM_REQ;
  - rr_ptr SHALL NOT change when there is no grant.
REQ-012 When no buffer is occupied, bus_valid SHALL be 0 at the next edge; the bus_* payload outputs SHALL hold their previous values.
REQ-013 A requester SHALL wait at most NUM_REQ-1 grants after its buffer becomes occupied (starvation bound, round-robin mode).
REQ-014 Flush SHALL take priority over all other events at an edge:
  - all buffers cleared;
  - bus_valid=0;
  - rr_ptr=0;
  - any request presented in the flush cycle is dropped.
REQ-015 Non-occupied buffers SHALL never be granted.
REQ-016 bus_src SHALL be NUM_REQ-1 or lower.

Reset
REQ-017 On rst at a rising edge:
  - all buffers SHALL be empty;
  - bus_valid=0, bus_src=0, bus_rob_idx=0, bus_rd_addr=0, bus_data=0;
  - rr_ptr=0.
REQ-018 rst asserted mid-operation SHALL discard buffered and in-flight results with no broadcast in the following cycle.
REQ-019 req_ready SHALL be 0 during the rst cycle and 1 for all units in the first cycle after.

Configuration
REQ-020 With CDB_AGE_PRIORITY_EN defined, the winner SHALL be the occupied buffer with the smallest age = (rob_idx - rob_head) mod 2^ROB_IDX_WIDTH.
  - Ties go to the lowest index.
  - rr_ptr is not used and is held at 0.
  - REQ-013 is replaced by: oldest-first, so a buffered result is bypassed only by older ones.
REQ-021 Without CDB_AGE_PRIORITY_EN, round-robin per REQ-011 SHALL apply and rob_head SHALL be ignored.

Verification
REQ-022 Single request, reset state, ALU: rob_idx=3, rd=5, data=0xDEADBEEF. Required: next cycle bus_valid=1, bus_src=0, rob_idx=3, rd=5, data=0xDEADBEEF; the cycle after, bus_valid=0.
REQ-023 All 4 units request in the same cycle, round-robin mode, rr_ptr=0. Required: grants ALU, MUL, BR, MEM on 4 consecutive cycles; req_ready of each waiting unit stays 0 until its buffer is granted or freed.
REQ-024 MUL holds req_valid=1 with new payloads every cycle while uncontended. Required: bus_valid=1 every cycle with matching payloads in order; req_ready[1] never drops.
REQ-025 Age mode, rob_head=30, ALU rob_idx=2, MEM rob_idx=31 in the same cycle. Required: MEM granted first (age 1), ALU next (age 4), which checks wrap-around.
REQ-026 Flush while 3 buffers are occupied and ALU presents a new request. Required: next cycle bus_valid=0; no stale result is ever broadcast; all req_ready=1 the cycle after.
REQ-027 rst asserted while BR is buffered. Required: no BR broadcast; all bus outputs 0.
